lcd_reg_viewer: RTL and testbench

// - Downstream consumer of the CPU top: snapshots three 16-bit register taps (r0, r1, r2) and shows them as hex on a 16x2 HD44780 LCD.
// - Runs the power-up init sequence, then rewrites both lines once per refresh frame while start is high.
// - Drives the LCD_* board pins directly.

---
 rtl/lcd_reg_viewer_pkg.sv | 61 ++++++
 rtl/lcd_write_cycle.sv | 100 ++++++++++
 rtl/lcd_reg_viewer.sv | 186 ++++++++++++++++++
 tb/tb_lcd_reg_viewer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_reg_viewer_pkg.sv
// Shared constants, state encodings and character helpers for the LCD register viewer.
// The HD44780 command bytes and ASCII glyphs used to build the two display lines.
package lcd_reg_viewer_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [7:0] ASC_R  = 8'h52;
  localparam logic [7:0] ASC_EQ = 8'h3D;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_1  = 8'h31;
  localparam logic [7:0] ASC_2  = 8'h32;

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_INIT,
    S_IDLE,
    S_LATCH,
    S_L1_ADDR,
    S_L1_CHAR,
    S_L2_ADDR,
    S_L2_CHAR,
    S_FIN
  } state_e;

  typedef enum logic [1:0] {
    WC_IDLE,
    WC_SETUP,
    WC_EN_HI,
    WC_WAIT
  } wc_phase_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASC_0 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // k = 0 selects the most significant nibble.
  function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] k);
    case (k)
      2'd0:    return v[15:12];
      2'd1:    return v[11:8];
      2'd2:    return v[7:4];
      default: return v[3:0];
    endcase
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_write_cycle.sv
// One HD44780 byte write: SETUP (1 cycle), EN high for EN_HIGH cycles, then a settle wait.
// ready is high when idle or in the final wait cycle, so a new go starts SETUP with no gap.
module lcd_write_cycle
  import lcd_reg_viewer_pkg::*;
#(
  parameter int EN_HIGH    = 12,
  parameter int CHAR_WAIT  = 2000,
  parameter int CLEAR_WAIT = 82000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic [7:0] LCD_DATA,
  output logic       ready
);

  localparam int MAXC = (CLEAR_WAIT > CHAR_WAIT) ?
                        ((CLEAR_WAIT > EN_HIGH) ? CLEAR_WAIT : EN_HIGH) :
                        ((CHAR_WAIT  > EN_HIGH) ? CHAR_WAIT  : EN_HIGH);
  localparam int CW = $clog2(MAXC + 1);

  wc_phase_e       phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   wait_last;
  logic            en_q, en_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            long_q, long_d;

  assign wait_last = long_q ? CW'(CLEAR_WAIT - 1) : CW'(CHAR_WAIT - 1);
  assign ready     = (phase_q == WC_IDLE) || ((phase_q == WC_WAIT) && (cnt_q == wait_last));

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    if (ready && go) begin
      phase_d = WC_SETUP;
      cnt_d   = '0;
      en_d    = 1'b0;
      rs_d    = rs;
      data_d  = data;
      long_d  = long_wait;
    end else begin
      case (phase_q)
        WC_SETUP: begin
          phase_d = WC_EN_HI;
          cnt_d   = '0;
          en_d    = 1'b1;
        end
        WC_EN_HI: begin
          if (cnt_q == CW'(EN_HIGH - 1)) begin
            phase_d = WC_WAIT;
            cnt_d   = '0;
            en_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WC_WAIT: begin
          // RS/DATA keep their last value through the wait and into idle.
          if (cnt_q == wait_last) phase_d = WC_IDLE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase_q <= WC_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

  assign LCD_EN   = en_q;
  assign LCD_RS   = rs_q;
  assign LCD_DATA = data_q;

endmodule

// File: rtl/lcd_reg_viewer.sv
// Snapshots r0/r1/r2 and paints them as hex on a 16x2 HD44780 after the power-up init.
// The byte for a state is issued on the transition into it, so state and pin activity line up.
module lcd_reg_viewer
  import lcd_reg_viewer_pkg::*;
#(
  parameter int INIT_WAIT  = 750000,
  parameter int EN_HIGH    = 12,
  parameter int CHAR_WAIT  = 2000,
  parameter int CLEAR_WAIT = 82000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] r0,
  input  logic [15:0] r1,
  input  logic [15:0] r2,
  output logic        busy,
  output logic        done,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_RS,
  output logic        LCD_ON,
  output logic        LCD_BLON
);

  localparam int PW = $clog2(INIT_WAIT + 1);

  state_e         state_q, state_d;
  logic [PW-1:0]  pwr_cnt_q, pwr_cnt_d;
  logic [3:0]     idx_q, idx_d;
  logic [15:0]    r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;

  logic           wr_go, wr_rs, wr_long, wr_ready;
  logic [7:0]     wr_data, l1_char, l2_char;

  always_comb begin
    state_d   = state_q;
    pwr_cnt_d = pwr_cnt_q;
    idx_d     = idx_q;
    r0_d      = r0_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    case (state_q)
      S_PWR_WAIT: begin
        if (pwr_cnt_q == PW'(INIT_WAIT - 1)) begin
          state_d   = S_INIT;
          pwr_cnt_d = '0;
          idx_d     = 4'd0;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 1'b1;
        end
      end
      S_INIT: begin
        if (wr_ready) begin
          if (idx_q == 4'd3) begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_IDLE: if (start) state_d = S_LATCH;
      S_LATCH: begin
        r0_d    = r0;
        r1_d    = r1;
        r2_d    = r2;
        state_d = S_L1_ADDR;
      end
      S_L1_ADDR: if (wr_ready) begin
        state_d = S_L1_CHAR;
        idx_d   = 4'd0;
      end
      S_L1_CHAR: if (wr_ready) begin
        if (idx_q == 4'd15) begin
          state_d = S_L2_ADDR;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_L2_ADDR: if (wr_ready) begin
        state_d = S_L2_CHAR;
        idx_d   = 4'd0;
      end
      S_L2_CHAR: if (wr_ready) begin
        if (idx_q == 4'd15) begin
          state_d = S_FIN;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_PWR_WAIT;
    endcase
  end

  // Glyphs are chosen from the upcoming index so the byte is ready when go fires.
  always_comb begin
    l1_char = ASC_SP;
    case (idx_d)
      4'd0, 4'd8:                l1_char = ASC_R;
      4'd1:                      l1_char = ASC_0;
      4'd9:                      l1_char = ASC_1;
      4'd2, 4'd10:               l1_char = ASC_EQ;
      4'd3, 4'd4, 4'd5, 4'd6:    l1_char = hex_ascii(nib(r0_q, 2'(idx_d - 4'd3)));
      4'd11, 4'd12, 4'd13, 4'd14: l1_char = hex_ascii(nib(r1_q, 2'(idx_d - 4'd11)));
      default: ;
    endcase
    l2_char = ASC_SP;
    case (idx_d)
      4'd0:                   l2_char = ASC_R;
      4'd1:                   l2_char = ASC_2;
      4'd2:                   l2_char = ASC_EQ;
      4'd3, 4'd4, 4'd5, 4'd6: l2_char = hex_ascii(nib(r2_q, 2'(idx_d - 4'd3)));
      default: ;
    endcase
  end

  always_comb begin
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    case (state_d)
      S_INIT:    wr_data = init_cmd(idx_d[1:0]);
      S_L1_ADDR: wr_data = CMD_LINE1;
      S_L2_ADDR: wr_data = CMD_LINE2;
      S_L1_CHAR: begin
        wr_rs   = 1'b1;
        wr_data = l1_char;
      end
      S_L2_CHAR: begin
        wr_rs   = 1'b1;
        wr_data = l2_char;
      end
      default: ;
    endcase
    wr_long = !wr_rs && (wr_data == CMD_CLEAR);
    wr_go   = ((state_d == S_INIT) || (state_d == S_L1_ADDR) || (state_d == S_L1_CHAR) ||
               (state_d == S_L2_ADDR) || (state_d == S_L2_CHAR)) &&
              ((state_d != state_q) || (idx_d != idx_q));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_PWR_WAIT;
      pwr_cnt_q <= '0;
      idx_q     <= 4'd0;
      r0_q      <= 16'h0;
      r1_q      <= 16'h0;
      r2_q      <= 16'h0;
    end else begin
      state_q   <= state_d;
      pwr_cnt_q <= pwr_cnt_d;
      idx_q     <= idx_d;
      r0_q      <= r0_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
    end
  end

  lcd_write_cycle #(
    .EN_HIGH   (EN_HIGH),
    .CHAR_WAIT (CHAR_WAIT),
    .CLEAR_WAIT(CLEAR_WAIT)
  ) u_wr (
    .clock    (clock),
    .reset_n  (reset_n),
    .go       (wr_go),
    .rs       (wr_rs),
    .data     (wr_data),
    .long_wait(wr_long),
    .LCD_EN   (LCD_EN),
    .LCD_RS   (LCD_RS),
    .LCD_DATA (LCD_DATA),
    .ready    (wr_ready)
  );

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

endmodule

// File: tb/tb_lcd_reg_viewer.sv
// Self-checking bench: captures every LCD write and compares against text built from the register values.
module tb_lcd_reg_viewer;

  localparam int INIT_WAIT   = 20;
  localparam int EN_HIGH     = 2;
  localparam int CHAR_WAIT   = 5;
  localparam int CLEAR_WAIT  = 10;
  localparam int BYTE_CYC    = 1 + EN_HIGH + CHAR_WAIT;
  localparam int FRAME_BYTES = 34;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] r0 = 16'h0, r1 = 16'h0, r2 = 16'h0;
  logic        busy, done, LCD_RW, LCD_EN, LCD_RS, LCD_ON, LCD_BLON;
  logic [7:0]  LCD_DATA;

  always #5 clock = ~clock;

  lcd_reg_viewer #(
    .INIT_WAIT(INIT_WAIT), .EN_HIGH(EN_HIGH), .CHAR_WAIT(CHAR_WAIT), .CLEAR_WAIT(CLEAR_WAIT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .r0(r0), .r1(r1), .r2(r2),
    .busy(busy), .done(done), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_RS(LCD_RS), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] byte_q[$];
  logic [8:0] exp_q[$];
  int rise_q[$], fall_q[$], done_q[$], brise_q[$], bfall_q[$], width_all[$];
  int viol = 0;
  int wcnt = 0;
  logic en_prev = 1'b0, busy_prev = 1'b0;
  logic [8:0] cap = '0;

  always @(posedge clock) cyc <= cyc + 1;

  // Bus monitor: one entry per EN pulse, plus busy/done edge stamps.
  always @(negedge clock) begin
    if (LCD_EN === 1'b1 && en_prev !== 1'b1) begin
      byte_q.push_back({LCD_RS, LCD_DATA});
      rise_q.push_back(cyc);
      cap  = {LCD_RS, LCD_DATA};
      wcnt = 1;
    end else if (LCD_EN === 1'b1) begin
      wcnt++;
      if ({LCD_RS, LCD_DATA} !== cap) viol++;
    end
    if (LCD_EN === 1'b0 && en_prev === 1'b1) begin
      fall_q.push_back(cyc);
      width_all.push_back(wcnt);
    end
    if (busy === 1'b1 && busy_prev === 1'b0) brise_q.push_back(cyc);
    if (busy === 1'b0 && busy_prev === 1'b1) bfall_q.push_back(cyc);
    if (done === 1'b1) done_q.push_back(cyc);
    en_prev   = LCD_EN;
    busy_prev = busy;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_mon();
    byte_q.delete(); rise_q.delete(); fall_q.delete();
    done_q.delete(); brise_q.delete(); bfall_q.delete();
  endtask

  // Reference: the two lines as text, uppercase hex, framed by the address commands.
  task automatic model_frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    string l1, l2;
    l1 = $sformatf("R0=%h R1=%h ", a, b);
    l1 = l1.toupper();
    l2 = $sformatf("R2=%h", c);
    l2 = l2.toupper();
    while (l2.len() < 16) l2 = {l2, " "};
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[i]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[i]});
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (LCD_EN !== 1'b0)      begin errors++; $display("FAIL reset_en: got %b expected 0", LCD_EN); end
    checks++; if (LCD_RS !== 1'b0)      begin errors++; $display("FAIL reset_rs: got %b expected 0", LCD_RS); end
    checks++; if (LCD_DATA !== 8'h00)   begin errors++; $display("FAIL reset_data: got %h expected 00", LCD_DATA); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++; if ({LCD_RW, LCD_ON, LCD_BLON} !== 3'b011)
      begin errors++; $display("FAIL tie_pins: got %b expected 011", {LCD_RW, LCD_ON, LCD_BLON}); end
  endtask

  // Releases reset (must be held on entry) and checks the power-up sequence.
  task automatic test_init(input string tag);
    int t0, n;
    logic [7:0] cmds[4];
    cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
    clear_mon();
    reset_n = 1'b1;
    t0 = cyc;
    n = 0;
    while (bfall_q.size() == 0 && n < 300) begin tick(); n++; end
    checks++;
    if (bfall_q.size() == 0) begin
      errors++; $display("FAIL %s_timeout: busy never dropped", tag);
      return;
    end
    checks++;
    if (rise_q[0] - t0 !== INIT_WAIT + 1)
      begin errors++; $display("FAIL %s_pwr_wait: first EN at %0d expected %0d", tag, rise_q[0] - t0, INIT_WAIT + 1); end
    checks++;
    if (byte_q.size() != 4 || fall_q.size() != 4) begin
      errors++; $display("FAIL %s_count: got %0d writes expected 4", tag, byte_q.size());
      return;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (byte_q[i] !== {1'b0, cmds[i]})
        begin errors++; $display("FAIL %s_cmd%0d: got %h expected %h", tag, i, byte_q[i], {1'b0, cmds[i]}); end
    end
    for (int i = 0; i < 3; i++) begin
      int g;
      g = (cmds[i] == 8'h01) ? CLEAR_WAIT : CHAR_WAIT;
      checks++;
      if (rise_q[i+1] - fall_q[i] !== g + 1)
        begin errors++; $display("FAIL %s_gap%0d: got %0d expected %0d", tag, i, rise_q[i+1] - fall_q[i], g + 1); end
    end
    checks++;
    if (bfall_q[0] - fall_q[3] !== CHAR_WAIT)
      begin errors++; $display("FAIL %s_idle: got %0d expected %0d", tag, bfall_q[0] - fall_q[3], CHAR_WAIT); end
  endtask

  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input string tag);
    int n;
    r0 = a; r1 = b; r2 = c;
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done_q.size() == 0 && n < 400) begin tick(); n++; end
    repeat (3) tick();
    model_frame(a, b, c);
    checks++;
    if (byte_q.size() != FRAME_BYTES || done_q.size() != 1 || brise_q.size() != 1) begin
      errors++;
      $display("FAIL %s_shape: bytes %0d dones %0d starts %0d expected %0d 1 1",
               tag, byte_q.size(), done_q.size(), brise_q.size(), FRAME_BYTES);
      return;
    end
    for (int i = 0; i < FRAME_BYTES; i++) begin
      checks++;
      if (byte_q[i] !== exp_q[i])
        begin errors++; $display("FAIL %s_byte%0d: got %h expected %h", tag, i, byte_q[i], exp_q[i]); end
    end
    checks++;
    if (done_q[0] - brise_q[0] !== FRAME_BYTES * BYTE_CYC + 1)
      begin errors++; $display("FAIL %s_latency: got %0d expected %0d", tag, done_q[0] - brise_q[0], FRAME_BYTES * BYTE_CYC + 1); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b expected 0", tag, busy); end
  endtask

  task automatic test_frame();
    run_frame(16'h1234, 16'hABCD, 16'h0F0F, "frame");
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 3; k++)
      run_frame(16'($urandom), 16'($urandom), 16'($urandom), $sformatf("rand%0d", k));
  endtask

  // start held high: two back-to-back frames, r0 changed mid-frame.
  task automatic test_back_to_back();
    int n;
    logic [15:0] b, c;
    b = 16'($urandom); c = 16'($urandom);
    r0 = 16'h1234; r1 = b; r2 = c;
    clear_mon();
    start = 1'b1;
    n = 0;
    while (byte_q.size() < 7 && n < 400) begin tick(); n++; end
    r0 = 16'hFFFF;
    n = 0;
    while (done_q.size() < 2 && n < 1000) begin
      tick(); n++;
      if (done_q.size() >= 2) start = 1'b0;
    end
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if (byte_q.size() != 2 * FRAME_BYTES || done_q.size() != 2 || brise_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_shape: bytes %0d dones %0d starts %0d expected %0d 2 2",
               byte_q.size(), done_q.size(), brise_q.size(), 2 * FRAME_BYTES);
      return;
    end
    model_frame(16'h1234, b, c);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      checks++;
      if (byte_q[i] !== exp_q[i])
        begin errors++; $display("FAIL b2b_f1_byte%0d: got %h expected %h", i, byte_q[i], exp_q[i]); end
    end
    model_frame(16'hFFFF, b, c);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      checks++;
      if (byte_q[FRAME_BYTES + i] !== exp_q[i])
        begin errors++; $display("FAIL b2b_f2_byte%0d: got %h expected %h", i, byte_q[FRAME_BYTES + i], exp_q[i]); end
    end
    checks++;
    if (brise_q[1] - done_q[0] !== 2)
      begin errors++; $display("FAIL b2b_idle_gap: got %0d expected 2", brise_q[1] - done_q[0]); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: busy %b expected 0", busy); end
  endtask

  task automatic test_en_timing();
    int bad;
    bad = 0;
    foreach (width_all[i]) if (width_all[i] != EN_HIGH) bad++;
    checks++;
    if (width_all.size() == 0 || bad != 0)
      begin errors++; $display("FAIL en_width: %0d of %0d pulses wrong, expected width %0d", bad, width_all.size(), EN_HIGH); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL en_stable: got %0d changes expected 0", viol); end
  endtask

  task automatic test_reset_mid();
    int n;
    r0 = 16'h5A5A; r1 = 16'h0001; r2 = 16'h7777;
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(byte_q.size() >= 3 && LCD_EN === 1'b1) && n < 400) begin tick(); n++; end
    checks++;
    if (LCD_EN !== 1'b1) begin errors++; $display("FAIL midrst_reach: EN %b expected 1", LCD_EN); end
    reset_n = 1'b0;
    tick();
    checks++; if (LCD_EN !== 1'b0) begin errors++; $display("FAIL midrst_en: got %b expected 0", LCD_EN); end
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL midrst_busy: got %b expected 1", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    tick();
    test_init("reinit");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_frame();
    test_random_frames();
    test_back_to_back();
    test_en_timing();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
